// File: rtl/axis_pkt_buffer.sv
// Store-and-forward AXI-Stream packet buffer: beats are held until the whole packet is committed.
// Define AXIS_PKT_BUF_DROP_EN to drop overflowing packets instead of back-pressuring the slave.
module axis_pkt_buffer #(
   parameter int P_DATA_WIDTH = 64,
   parameter int P_KEEP_WIDTH = 8,
   parameter int P_USER_WIDTH = 16,
   parameter int P_DEPTH      = 1024,
   parameter int P_PKT_DEPTH  = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [P_DATA_WIDTH-1:0] i_s_axis_data,
   input  logic [P_USER_WIDTH-1:0] i_s_axis_user,
   input  logic [P_KEEP_WIDTH-1:0] i_s_axis_keep,
   input  logic                    i_s_axis_last,
   input  logic                    i_s_axis_valid,
   output logic                    o_s_axis_ready,
   output logic [P_DATA_WIDTH-1:0] o_m_axis_data,
   output logic [P_USER_WIDTH-1:0] o_m_axis_user,
   output logic [15:0]             o_m_axis_len,
   output logic [P_KEEP_WIDTH-1:0] o_m_axis_keep,
   output logic                    o_m_axis_last,
   output logic                    o_m_axis_valid,
   input  logic                    i_m_axis_ready,
   output logic [15:0]             o_pkt_cnt,
   output logic [15:0]             o_drop_cnt
);
   localparam int AW     = $clog2(P_DEPTH);
   localparam int PW     = $clog2(P_PKT_DEPTH);
   localparam int DESC_W = 16 + P_KEEP_WIDTH + P_USER_WIDTH;

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   logic [P_DATA_WIDTH-1:0] data_mem [P_DEPTH];
   logic [DESC_W-1:0]       desc_mem [P_PKT_DEPTH];

   logic [AW:0]             wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
   logic [PW:0]             dwr_ptr_q, dwr_ptr_d, drd_ptr_q, drd_ptr_d;
   logic [15:0]             beat_cnt_q, beat_cnt_d, send_cnt_q, send_cnt_d;
   logic [15:0]             pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [P_USER_WIDTH-1:0] first_user_q, first_user_d, m_user_q, m_user_d;
   logic [P_KEEP_WIDTH-1:0] last_keep_q, last_keep_d, m_keep_q, m_keep_d;
   logic [P_DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [15:0]             m_len_q, m_len_d;
   logic                    m_last_q, m_last_d, m_valid_q, m_valid_d;
   logic                    s_ready_q, s_ready_d;
   state_t                  state_q, state_d;
`ifdef AXIS_PKT_BUF_DROP_EN
   logic                    drop_pkt_q, drop_pkt_d;
`endif

   logic                    s_accept, m_xfer, desc_empty, mem_we, desc_we, next_last;
   logic [DESC_W-1:0]       desc_wdata, desc_rd;
   logic [15:0]             desc_len;
   logic [P_KEEP_WIDTH-1:0] desc_keep;
   logic [P_USER_WIDTH-1:0] desc_user;

   // Full when the pointers differ only in the extra wrap bit
   function automatic logic data_is_full(input logic [AW:0] w, input logic [AW:0] r);
      return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
   endfunction

   function automatic logic desc_is_full(input logic [PW:0] w, input logic [PW:0] r);
      return (w[PW] != r[PW]) && (w[PW-1:0] == r[PW-1:0]);
   endfunction

   assign desc_rd   = desc_mem[drd_ptr_q[PW-1:0]];
   assign desc_len  = desc_rd[DESC_W-1 -: 16];
   assign desc_keep = desc_rd[P_USER_WIDTH +: P_KEEP_WIDTH];
   assign desc_user = desc_rd[P_USER_WIDTH-1:0];
   assign rd_next   = rd_ptr_q + 1'b1;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      cmt_ptr_d    = cmt_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      dwr_ptr_d    = dwr_ptr_q;
      drd_ptr_d    = drd_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      send_cnt_d   = send_cnt_q;
      pkt_cnt_d    = pkt_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      first_user_d = first_user_q;
      last_keep_d  = last_keep_q;
      m_data_d     = m_data_q;
      m_user_d     = m_user_q;
      m_len_d      = m_len_q;
      m_keep_d     = m_keep_q;
      m_last_d     = m_last_q;
      m_valid_d    = m_valid_q;
      state_d      = state_q;
      mem_we       = 1'b0;
      desc_we      = 1'b0;
      next_last    = 1'b0;
      s_accept     = i_s_axis_valid && s_ready_q;
      m_xfer       = m_valid_q && i_m_axis_ready;
      desc_empty   = (dwr_ptr_q == drd_ptr_q);
      desc_wdata   = {beat_cnt_q + 16'd1, i_s_axis_keep,
                      (beat_cnt_q == 16'd0) ? i_s_axis_user : first_user_q};
`ifdef AXIS_PKT_BUF_DROP_EN
      drop_pkt_d   = drop_pkt_q;
      if (s_accept) begin
         if (drop_pkt_q) begin
            if (i_s_axis_last) drop_pkt_d = 1'b0;
         end else if (data_is_full(wr_ptr_q, rd_ptr_q) || desc_is_full(dwr_ptr_q, drd_ptr_q)) begin
            // Overflow: forget the partial packet and swallow the rest of it
            wr_ptr_d   = cmt_ptr_q;
            beat_cnt_d = 16'd0;
            drop_pkt_d = !i_s_axis_last;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
         end else begin
            mem_we = 1'b1;
         end
      end
`else
      mem_we = s_accept;
`endif
      if (mem_we) begin
         wr_ptr_d   = wr_ptr_q + 1'b1;
         beat_cnt_d = beat_cnt_q + 16'd1;
         if (beat_cnt_q == 16'd0) first_user_d = i_s_axis_user;
         if (i_s_axis_last) begin
            desc_we    = 1'b1;
            beat_cnt_d = 16'd0;
            cmt_ptr_d  = wr_ptr_q + 1'b1;
            dwr_ptr_d  = dwr_ptr_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: if (!desc_empty && (cmt_ptr_q != rd_ptr_q)) state_d = LOAD;
         LOAD: begin
            drd_ptr_d   = drd_ptr_q + 1'b1;
            m_len_d     = desc_len;
            m_user_d    = desc_user;
            last_keep_d = desc_keep;
            m_data_d    = data_mem[rd_ptr_q[AW-1:0]];
            m_valid_d   = 1'b1;
            send_cnt_d  = 16'd1;
            m_last_d    = (desc_len == 16'd1);
            m_keep_d    = (desc_len == 16'd1) ? desc_keep : '1;
            state_d     = SEND;
         end
         SEND: begin
            if (m_xfer) begin
               rd_ptr_d = rd_next;
               if (m_last_q) begin
                  m_valid_d = 1'b0;
                  m_last_d  = 1'b0;
                  state_d   = desc_empty ? IDLE : LOAD;
               end else begin
                  next_last  = ((send_cnt_q + 16'd1) == m_len_q);
                  send_cnt_d = send_cnt_q + 16'd1;
                  m_data_d   = data_mem[rd_next[AW-1:0]];
                  m_last_d   = next_last;
                  m_keep_d   = next_last ? last_keep_q : '1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case ({desc_we, m_xfer && m_last_q})
         2'b10:   pkt_cnt_d = pkt_cnt_q + 16'd1;
         2'b01:   pkt_cnt_d = pkt_cnt_q - 16'd1;
         default: pkt_cnt_d = pkt_cnt_q;
      endcase

`ifdef AXIS_PKT_BUF_DROP_EN
      s_ready_d = 1'b1;
`else
      // Look at next-state occupancy so a beat that fills the store drops ready one cycle later
      s_ready_d = !data_is_full(wr_ptr_d, rd_ptr_d) && !desc_is_full(dwr_ptr_d, drd_ptr_d);
`endif
   end

   always_ff @(posedge i_clk) begin
      if (mem_we)  data_mem[wr_ptr_q[AW-1:0]]  <= i_s_axis_data;
      if (desc_we) desc_mem[dwr_ptr_q[PW-1:0]] <= desc_wdata;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q     <= '0;
         cmt_ptr_q    <= '0;
         rd_ptr_q     <= '0;
         dwr_ptr_q    <= '0;
         drd_ptr_q    <= '0;
         beat_cnt_q   <= '0;
         send_cnt_q   <= '0;
         pkt_cnt_q    <= '0;
         drop_cnt_q   <= '0;
         first_user_q <= '0;
         last_keep_q  <= '1;
         m_data_q     <= '0;
         m_user_q     <= '0;
         m_len_q      <= '0;
         m_keep_q     <= '1;
         m_last_q     <= 1'b0;
         m_valid_q    <= 1'b0;
         s_ready_q    <= 1'b0;
         state_q      <= IDLE;
`ifdef AXIS_PKT_BUF_DROP_EN
         drop_pkt_q   <= 1'b0;
`endif
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         cmt_ptr_q    <= cmt_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         dwr_ptr_q    <= dwr_ptr_d;
         drd_ptr_q    <= drd_ptr_d;
         beat_cnt_q   <= beat_cnt_d;
         send_cnt_q   <= send_cnt_d;
         pkt_cnt_q    <= pkt_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         first_user_q <= first_user_d;
         last_keep_q  <= last_keep_d;
         m_data_q     <= m_data_d;
         m_user_q     <= m_user_d;
         m_len_q      <= m_len_d;
         m_keep_q     <= m_keep_d;
         m_last_q     <= m_last_d;
         m_valid_q    <= m_valid_d;
         s_ready_q    <= s_ready_d;
         state_q      <= state_d;
`ifdef AXIS_PKT_BUF_DROP_EN
         drop_pkt_q   <= drop_pkt_d;
`endif
      end
   end

   assign o_s_axis_ready = s_ready_q;
   assign o_m_axis_data  = m_data_q;
   assign o_m_axis_user  = m_user_q;
   assign o_m_axis_len   = m_len_q;
   assign o_m_axis_keep  = m_keep_q;
   assign o_m_axis_last  = m_last_q;
   assign o_m_axis_valid = m_valid_q;
   assign o_pkt_cnt      = pkt_cnt_q;
   assign o_drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_axis_pkt_buffer.sv
// Directed bench for axis_pkt_buffer with a 16-beat data store; the overflow scenario
// follows whichever build of AXIS_PKT_BUF_DROP_EN is compiled.
module tb_axis_pkt_buffer;
   localparam int DW = 64;
   localparam int KW = 8;
   localparam int UW = 16;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [DW-1:0] i_s_axis_data = '0;
   logic [UW-1:0] i_s_axis_user = '0;
   logic [KW-1:0] i_s_axis_keep = '0;
   logic          i_s_axis_last = 1'b0;
   logic          i_s_axis_valid = 1'b0;
   logic          i_m_axis_ready = 1'b0;
   logic          o_s_axis_ready;
   logic [DW-1:0] o_m_axis_data;
   logic [UW-1:0] o_m_axis_user;
   logic [15:0]   o_m_axis_len;
   logic [KW-1:0] o_m_axis_keep;
   logic          o_m_axis_last;
   logic          o_m_axis_valid;
   logic [15:0]   o_pkt_cnt;
   logic [15:0]   o_drop_cnt;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_acc_cyc = 0;
   int stall_viol = 0;

   logic [DW-1:0] q_data[$];
   logic [UW-1:0] q_user[$];
   logic [15:0]   q_len[$];
   logic [KW-1:0] q_keep[$];
   logic          q_last[$];
   int            q_cyc[$];

   axis_pkt_buffer #(
      .P_DATA_WIDTH(DW), .P_KEEP_WIDTH(KW), .P_USER_WIDTH(UW), .P_DEPTH(16), .P_PKT_DEPTH(16)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_s_axis_data(i_s_axis_data), .i_s_axis_user(i_s_axis_user), .i_s_axis_keep(i_s_axis_keep),
      .i_s_axis_last(i_s_axis_last), .i_s_axis_valid(i_s_axis_valid), .o_s_axis_ready(o_s_axis_ready),
      .o_m_axis_data(o_m_axis_data), .o_m_axis_user(o_m_axis_user), .o_m_axis_len(o_m_axis_len),
      .o_m_axis_keep(o_m_axis_keep), .o_m_axis_last(o_m_axis_last), .o_m_axis_valid(o_m_axis_valid),
      .i_m_axis_ready(i_m_axis_ready), .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Drives one packet beat by beat; user is only meaningful on the first beat, keep on the last
   task automatic send_pkt(input int n, input logic [UW-1:0] user, input logic [KW-1:0] keep,
                           input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         int   budget;
         logic acc;
         budget = 200;
         acc = 1'b0;
         i_s_axis_valid = 1'b1;
         i_s_axis_data  = base + DW'(i);
         i_s_axis_last  = (i == n - 1);
         i_s_axis_user  = (i == 0) ? user : 16'hFFFF;
         i_s_axis_keep  = (i == n - 1) ? keep : 8'h00;
         while (!acc && budget > 0) begin
            @(negedge i_clk);
            acc = o_s_axis_ready;
            if (acc && i_s_axis_last) last_acc_cyc = cyc;
            @(posedge i_clk);
            #1;
            budget--;
         end
         if (!acc) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL send_timeout: beat %0d never accepted, ready=%b expected 1", i, o_s_axis_ready);
         end
      end
      i_s_axis_valid = 1'b0;
      i_s_axis_last  = 1'b0;
   endtask

   // Records master transfers; mode 0 = always ready, 1 = random ready
   task automatic collect(input int n, input int mode, input int budget);
      logic         stalled;
      logic [105:0] saved;
      logic [105:0] cur;
      int           got;
      stalled = 1'b0;
      saved = '0;
      got = 0;
      q_data.delete(); q_user.delete(); q_len.delete();
      q_keep.delete(); q_last.delete(); q_cyc.delete();
      while (got < n && budget > 0) begin
         i_m_axis_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
         @(negedge i_clk);
         cur = {o_m_axis_valid, o_m_axis_data, o_m_axis_user, o_m_axis_len, o_m_axis_keep, o_m_axis_last};
         if (stalled && (cur !== saved)) stall_viol++;
         if (o_m_axis_valid && i_m_axis_ready) begin
            q_data.push_back(o_m_axis_data);
            q_user.push_back(o_m_axis_user);
            q_len.push_back(o_m_axis_len);
            q_keep.push_back(o_m_axis_keep);
            q_last.push_back(o_m_axis_last);
            q_cyc.push_back(cyc);
            got++;
         end
         stalled = o_m_axis_valid && !i_m_axis_ready;
         saved = cur;
         @(posedge i_clk);
         #1;
         budget--;
      end
      i_m_axis_ready = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      n_checks++; if (o_s_axis_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", o_s_axis_ready); end
      n_checks++; if (o_m_axis_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", o_m_axis_valid); end
      n_checks++; if (o_m_axis_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_last: got %b expected 0", o_m_axis_last); end
      n_checks++; if (o_m_axis_data !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %0h expected 0", o_m_axis_data); end
      n_checks++; if (o_m_axis_user !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_user: got %0h expected 0", o_m_axis_user); end
      n_checks++; if (o_m_axis_len !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_len: got %0d expected 0", o_m_axis_len); end
      n_checks++; if (o_m_axis_keep !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_keep: got %0h expected ff", o_m_axis_keep); end
      n_checks++; if (o_pkt_cnt !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_pkt_cnt: got %0d expected 0", o_pkt_cnt); end
      n_checks++; if (o_drop_cnt !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", o_drop_cnt); end
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      n_checks++; if (o_s_axis_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_after_reset: got %b expected 1", o_s_axis_ready); end
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_four_beat();
      int lat;
      fork
         send_pkt(4, 16'h00A5, 8'h0F, 64'h100);
         collect(4, 0, 60);
      join
      n_checks++; if (q_data.size() != 4) begin n_fail++; $display("[TB] FAIL four_beat_count: got %0d expected 4", q_data.size()); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (q_data[i] !== 64'h100 + 64'(i)) begin n_fail++; $display("[TB] FAIL four_beat_data[%0d]: got %0h expected %0h", i, q_data[i], 64'h100 + 64'(i)); end
         n_checks++; if (q_keep[i] !== ((i == 3) ? 8'h0F : 8'hFF)) begin n_fail++; $display("[TB] FAIL four_beat_keep[%0d]: got %0h expected %0h", i, q_keep[i], (i == 3) ? 8'h0F : 8'hFF); end
         n_checks++; if (q_last[i] !== (i == 3)) begin n_fail++; $display("[TB] FAIL four_beat_last[%0d]: got %b expected %b", i, q_last[i], (i == 3)); end
         n_checks++; if (q_len[i] !== 16'd4) begin n_fail++; $display("[TB] FAIL four_beat_len[%0d]: got %0d expected 4", i, q_len[i]); end
         n_checks++; if (q_user[i] !== 16'h00A5) begin n_fail++; $display("[TB] FAIL four_beat_user[%0d]: got %0h expected a5", i, q_user[i]); end
      end
      lat = (q_cyc.size() > 0) ? q_cyc[0] - last_acc_cyc : 999;
      n_checks++; if (lat < 1 || lat > 3) begin n_fail++; $display("[TB] FAIL four_beat_latency: got %0d cycles expected 1..3", lat); end
      n_checks++; if (o_pkt_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL four_beat_pkt_cnt: got %0d expected 0", o_pkt_cnt); end
   endtask

   task automatic test_one_beat();
      fork
         send_pkt(1, 16'h1234, 8'h01, 64'h200);
         collect(1, 0, 40);
      join
      n_checks++; if (q_data.size() != 1) begin n_fail++; $display("[TB] FAIL one_beat_count: got %0d expected 1", q_data.size()); end
      n_checks++; if (q_data[0] !== 64'h200) begin n_fail++; $display("[TB] FAIL one_beat_data: got %0h expected 200", q_data[0]); end
      n_checks++; if (q_last[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL one_beat_last: got %b expected 1", q_last[0]); end
      n_checks++; if (q_keep[0] !== 8'h01) begin n_fail++; $display("[TB] FAIL one_beat_keep: got %0h expected 01", q_keep[0]); end
      n_checks++; if (q_len[0] !== 16'd1) begin n_fail++; $display("[TB] FAIL one_beat_len: got %0d expected 1", q_len[0]); end
      n_checks++; if (q_user[0] !== 16'h1234) begin n_fail++; $display("[TB] FAIL one_beat_user: got %0h expected 1234", q_user[0]); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_user;
      // Two packets stored while stalled, then drained with ready held high
      i_m_axis_ready = 1'b0;
      send_pkt(2, 16'h0A01, 8'h03, 64'h500);
      send_pkt(2, 16'h0A02, 8'h07, 64'h600);
      n_checks++; if (o_pkt_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL b2b_pkt_cnt_stored: got %0d expected 2", o_pkt_cnt); end
      collect(4, 0, 40);
      n_checks++; if (q_data.size() != 4) begin n_fail++; $display("[TB] FAIL b2b_gap_count: got %0d expected 4", q_data.size()); end
      n_checks++; if (q_cyc[2] - q_cyc[1] > 2) begin n_fail++; $display("[TB] FAIL b2b_gap: got %0d cycles expected <= 2", q_cyc[2] - q_cyc[1]); end
      n_checks++; if (q_data[2] !== 64'h600) begin n_fail++; $display("[TB] FAIL b2b_gap_data: got %0h expected 600", q_data[2]); end

      stall_viol = 0;
      fork
         begin
            send_pkt(2, 16'h0B00, 8'h0F, 64'h700);
            send_pkt(2, 16'h0B01, 8'h0F, 64'h710);
            send_pkt(2, 16'h0B02, 8'h0F, 64'h720);
         end
         collect(6, 1, 400);
      join
      n_checks++; if (q_data.size() != 6) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 6", q_data.size()); end
      for (int i = 0; i < 6; i++) begin
         exp_user = 16'h0B00 + 16'(i / 2);
         n_checks++; if (q_data[i] !== 64'h700 + 64'((i / 2) * 16 + (i % 2))) begin n_fail++; $display("[TB] FAIL b2b_data[%0d]: got %0h expected %0h", i, q_data[i], 64'h700 + 64'((i / 2) * 16 + (i % 2))); end
         n_checks++; if (q_last[i] !== (i % 2 == 1)) begin n_fail++; $display("[TB] FAIL b2b_last[%0d]: got %b expected %b", i, q_last[i], (i % 2 == 1)); end
         n_checks++; if (q_user[i] !== exp_user) begin n_fail++; $display("[TB] FAIL b2b_user[%0d]: got %0h expected %0h", i, q_user[i], exp_user); end
      end
      n_checks++; if (stall_viol != 0) begin n_fail++; $display("[TB] FAIL b2b_stall_stable: got %0d changes expected 0", stall_viol); end
      n_checks++; if (o_pkt_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL b2b_pkt_cnt: got %0d expected 0", o_pkt_cnt); end
   endtask

`ifdef AXIS_PKT_BUF_DROP_EN
   task automatic test_overflow();
      fork
         send_pkt(20, 16'h0D00, 8'hFF, 64'h800);
         collect(1, 0, 30);
      join
      n_checks++; if (q_data.size() != 0) begin n_fail++; $display("[TB] FAIL drop_no_output: got %0d beats expected 0", q_data.size()); end
      n_checks++; if (o_drop_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL drop_cnt: got %0d expected 1", o_drop_cnt); end
      n_checks++; if (o_s_axis_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_ready: got %b expected 1", o_s_axis_ready); end
      n_checks++; if (o_pkt_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL drop_pkt_cnt: got %0d expected 0", o_pkt_cnt); end
      fork
         send_pkt(3, 16'h0D01, 8'h3F, 64'h900);
         collect(3, 0, 40);
      join
      n_checks++; if (q_data.size() != 3) begin n_fail++; $display("[TB] FAIL drop_next_count: got %0d expected 3", q_data.size()); end
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (q_data[i] !== 64'h900 + 64'(i)) begin n_fail++; $display("[TB] FAIL drop_next_data[%0d]: got %0h expected %0h", i, q_data[i], 64'h900 + 64'(i)); end
      end
      n_checks++; if (q_keep[2] !== 8'h3F) begin n_fail++; $display("[TB] FAIL drop_next_keep: got %0h expected 3f", q_keep[2]); end
      n_checks++; if (q_len[0] !== 16'd3) begin n_fail++; $display("[TB] FAIL drop_next_len: got %0d expected 3", q_len[0]); end
      n_checks++; if (o_drop_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL drop_cnt_after: got %0d expected 1", o_drop_cnt); end
   endtask
`else
   task automatic test_overflow();
      i_m_axis_ready = 1'b0;
      send_pkt(8, 16'h0E00, 8'hFF, 64'hA00);
      send_pkt(8, 16'h0E01, 8'h1F, 64'hB00);
      @(negedge i_clk);
      n_checks++; if (o_s_axis_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_full: got %b expected 0", o_s_axis_ready); end
      repeat (4) @(negedge i_clk);
      n_checks++; if (o_s_axis_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_held: got %b expected 0", o_s_axis_ready); end
      n_checks++; if (o_pkt_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL bp_pkt_cnt: got %0d expected 2", o_pkt_cnt); end
      n_checks++; if (o_drop_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL bp_drop_cnt: got %0d expected 0", o_drop_cnt); end
      @(posedge i_clk);
      #1;
      collect(16, 0, 100);
      n_checks++; if (q_data.size() != 16) begin n_fail++; $display("[TB] FAIL bp_drain_count: got %0d expected 16", q_data.size()); end
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (q_data[i] !== ((i < 8) ? 64'hA00 + 64'(i) : 64'hB00 + 64'(i - 8))) begin n_fail++; $display("[TB] FAIL bp_data[%0d]: got %0h expected %0h", i, q_data[i], (i < 8) ? 64'hA00 + 64'(i) : 64'hB00 + 64'(i - 8)); end
      end
      n_checks++; if (q_keep[15] !== 8'h1F) begin n_fail++; $display("[TB] FAIL bp_last_keep: got %0h expected 1f", q_keep[15]); end
      @(negedge i_clk);
      n_checks++; if (o_s_axis_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_drained: got %b expected 1", o_s_axis_ready); end
      n_checks++; if (o_pkt_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL bp_pkt_cnt_drained: got %0d expected 0", o_pkt_cnt); end
      @(posedge i_clk);
      #1;
   endtask
`endif

   task automatic test_reset_mid_packet();
      int budget;
      logic acc;
      // A complete packet waits in the store while a second one is cut off by reset
      i_m_axis_ready = 1'b0;
      send_pkt(3, 16'h0F00, 8'h0F, 64'hC00);
      i_s_axis_valid = 1'b1;
      i_s_axis_data  = 64'hD00;
      i_s_axis_user  = 16'h0F01;
      i_s_axis_keep  = 8'h00;
      i_s_axis_last  = 1'b0;
      budget = 50;
      acc = 1'b0;
      while (!acc && budget > 0) begin
         @(negedge i_clk);
         acc = o_s_axis_ready;
         @(posedge i_clk);
         #1;
         budget--;
      end
      i_s_axis_data = 64'hD01;
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      n_checks++; if (o_s_axis_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_ready: got %b expected 0", o_s_axis_ready); end
      n_checks++; if (o_m_axis_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", o_m_axis_valid); end
      n_checks++; if (o_m_axis_data !== 64'h0) begin n_fail++; $display("[TB] FAIL rst_mid_data: got %0h expected 0", o_m_axis_data); end
      n_checks++; if (o_m_axis_len !== 16'h0) begin n_fail++; $display("[TB] FAIL rst_mid_len: got %0d expected 0", o_m_axis_len); end
      n_checks++; if (o_m_axis_user !== 16'h0) begin n_fail++; $display("[TB] FAIL rst_mid_user: got %0h expected 0", o_m_axis_user); end
      n_checks++; if (o_m_axis_keep !== 8'hFF) begin n_fail++; $display("[TB] FAIL rst_mid_keep: got %0h expected ff", o_m_axis_keep); end
      n_checks++; if (o_pkt_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_mid_pkt_cnt: got %0d expected 0", o_pkt_cnt); end
      @(posedge i_clk);
      #1;
      i_s_axis_valid = 1'b0;
      i_rst = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      n_checks++; if (o_s_axis_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_ready_release: got %b expected 1", o_s_axis_ready); end
      @(posedge i_clk);
      #1;
      collect(1, 0, 30);
      n_checks++; if (q_data.size() != 0) begin n_fail++; $display("[TB] FAIL rst_mid_no_output: got %0d beats expected 0", q_data.size()); end
      fork
         send_pkt(2, 16'h0F02, 8'h03, 64'hE00);
         collect(2, 0, 40);
      join
      n_checks++; if (q_data.size() != 2) begin n_fail++; $display("[TB] FAIL rst_mid_next_count: got %0d expected 2", q_data.size()); end
      n_checks++; if (q_len[0] !== 16'd2) begin n_fail++; $display("[TB] FAIL rst_mid_next_len: got %0d expected 2", q_len[0]); end
      n_checks++; if (q_data[0] !== 64'hE00) begin n_fail++; $display("[TB] FAIL rst_mid_next_data: got %0h expected e00", q_data[0]); end
      n_checks++; if (q_user[1] !== 16'h0F02) begin n_fail++; $display("[TB] FAIL rst_mid_next_user: got %0h expected f02", q_user[1]); end
   endtask

   initial begin
      test_reset();
      test_four_beat();
      test_one_beat();
      test_back_to_back();
      test_overflow();
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/axis_pkt_buffer.md
AXIS_PKT_BUFFER -- requirements
Module: axis_pkt_buffer

Interface
REQ-001 The block SHALL have parameter P_DATA_WIDTH, default 64, meaning beat data width in bits.
REQ-002 The block SHALL have parameter P_KEEP_WIDTH, default 8, meaning keep width, equal to P_DATA_WIDTH/8.
REQ-003 The block SHALL have parameter P_USER_WIDTH, default 16, meaning packet user/tag width.
REQ-004 The block SHALL have parameter P_DEPTH, default 1024, meaning data store depth in beats (power of 2, max 65536).
REQ-005 The block SHALL have parameter P_PKT_DEPTH, default 16, meaning descriptor store depth in packets (power of 2).
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset, with ports i_clk and i_rst.
REQ-007 The block SHALL have these ports:
i_clk  in  1  sole clock
i_rst  in  1  async active-high reset
i_s_axis_data  in  P_DATA_WIDTH  slave data
i_s_axis_user  in  P_USER_WIDTH  slave user, sampled on first beat
i_s_axis_keep  in  P_KEEP_WIDTH  slave keep, sampled on last beat
i_s_axis_last  in  1  slave last
i_s_axis_valid  in  1  slave valid
o_s_axis_ready  out  1  slave ready
o_m_axis_data  out  P_DATA_WIDTH  master data
o_m_axis_user  out  P_USER_WIDTH  first-beat user of current packet
o_m_axis_len  out  16  current packet length in beats
o_m_axis_keep  out  P_KEEP_WIDTH  master keep
o_m_axis_last  out  1  master last
o_m_axis_valid  out  1  master valid
i_m_axis_ready  in  1  master ready
o_pkt_cnt  out  16  committed packets not yet fully sent
o_drop_cnt  out  16  dropped packets, saturating

Function
REQ-008 A slave beat SHALL be accepted when i_s_axis_valid && o_s_axis_ready, and a master beat transferred when o_m_axis_valid && i_m_axis_ready.
REQ-009 The block SHALL forward whole packets only (store-and-forward): no beat of a packet appears on the master side before its last beat has been accepted.
REQ-010 The block SHALL maintain a write pointer and a commit pointer; on the last accepted beat it SHALL advance the commit pointer and push a descriptor {length, last keep, first user}.
REQ-011 The length SHALL be counted in a 16-bit beat counter that resets to 0 after each last beat; a 1-beat packet SHALL have length 1.
REQ-012 o_s_axis_ready SHALL be deasserted in the cycle after data store full or descriptor store full, and SHALL be registered.
REQ-013 The read side SHALL use a FSM with states IDLE (descriptor store empty), LOAD (pop descriptor, prefetch first beat), SEND (present beats), returning from SEND to IDLE or LOAD after the last beat's transfer.
REQ-014 The first o_m_axis_valid of a packet SHALL assert no later than 3 cycles after the cycle its last slave beat was accepted, provided the read side is IDLE.
REQ-015 While o_m_axis_valid && !i_m_axis_ready, all master outputs SHALL hold stable.
REQ-016 Back-to-back packets SHALL be sent with at most one idle cycle between the last beat and the next first beat.
REQ-017 o_m_axis_keep SHALL be all-ones on non-last beats and the stored keep on the last beat; o_m_axis_last SHALL assert only on beat number length.
REQ-018 o_m_axis_user and o_m_axis_len SHALL be constant for all beats of a packet.
REQ-019 o_pkt_cnt SHALL increment on commit, decrement on last-beat transfer, and be unchanged when both occur in one cycle.
REQ-020 Pointer arithmetic SHALL wrap modulo P_DEPTH; full/empty SHALL be distinguished by one extra pointer bit.

Reset
REQ-021 On i_rst all pointers, counters and the FSM (to IDLE) SHALL clear; o_s_axis_ready, o_m_axis_valid, o_m_axis_last SHALL be 0; data, user, len SHALL be 0; keep SHALL be all-ones.
REQ-022 Reset mid-packet SHALL discard all stored and partially written packets; o_s_axis_ready SHALL assert the first cycle after reset release.

Configuration
REQ-023 With macro AXIS_PKT_BUF_DROP_EN defined, o_s_axis_ready SHALL stay 1 except during reset; a packet that meets a full data or descriptor store SHALL have its write pointer rolled back to the commit pointer, its remaining beats through last SHALL be discarded, and o_drop_cnt SHALL increment once.
REQ-024 Without AXIS_PKT_BUF_DROP_EN, the block SHALL back-pressure per REQ-012, o_drop_cnt SHALL be tied to 0, and packets longer than P_DEPTH beats are unsupported.

Verification
REQ-025 The bench SHALL cover the case of a 4-beat packet, user=0x00A5, last keep=0x0F with i_m_axis_ready=1, which SHALL produce 4 master beats, len=4, keep FF,FF,FF,0F, and last on beat 4.
REQ-026 The bench SHALL cover the case of a 1-beat packet, keep=0x01, which SHALL produce a single beat with last=1, keep=0x01, and len=1.
REQ-027 The bench SHALL cover the case of three back-to-back 2-beat packets with random i_m_axis_ready, which SHALL produce data in order, outputs stable while stalled, and o_pkt_cnt returning to 0.
REQ-028 The bench SHALL cover the case of P_DEPTH=16 with a 20-beat packet and drop enabled, which SHALL produce no master output, o_drop_cnt=1, and a following 3-beat packet delivered intact.
REQ-029 The bench SHALL cover the case of P_DEPTH=16 with drop disabled and i_m_axis_ready=0 with 2x8-beat packets, which SHALL deassert o_s_axis_ready after 16 accepted beats and reassert it after the drain.
REQ-030 The bench SHALL cover the case of an i_rst pulse during beat 2 of a 5-beat input, which SHALL produce all outputs at reset values, o_pkt_cnt=0, and no partial packet emitted afterwards.
